fp_multiplier_pipe: RTL and testbench
=====================================

# fp_multiplier_pipe

Pipelined, parametrised IEEE-754-style floating-point multiplier. It is the successor to the combinational single-precision multiplier unit, adding five things:
- generic exponent/mantissa widths;
- round-to-nearest-even;
- overflow/underflow handling;
- a 3-stage pipeline;
- valid/ready handshakes on input and output.

It sits between the operand-issue logic and the result writeback / special-case decoder.

## Interface
- EXP_W, 8, exponent field width (≥3)
- MAN_W, 23, stored mantissa (fraction) width (≥2)
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  operand pair valid
- in_ready  out  1  block accepts operands this cycle
- dataA  in  1+EXP_W+MAN_W  operand A {sign, exp, frac}
- dataB  in  1+EXP_W+MAN_W  operand B
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- dataR  out  1+EXP_W+MAN_W  product
- casesspecial  out  4  {zero, +inf, -inf, nan}, one-hot or all-zero

## Operation
- BIAS = 2^(EXP_W-1)-1. Exp field all-ones with frac≠0 is NaN; all-ones with frac=0 is Inf; exp=0 is zero (subnormals flush to zero, sign kept).
- Result sign = signA ^ signB for every non-NaN result.
- Special-case priority (highest first):
  - NaN: either input NaN, or Inf×zero → canonical NaN {0, all-ones, 1 followed by zeros}, flag 0001.
  - Inf: either input Inf → {sign, all-ones, 0}; flag 0100 if sign=0, 0010 if sign=1.
  - Zero: either input zero → {sign, 0, 0}, flag 1000.
- Normal path:
  - Product P = {1,fracA}×{1,fracB}, width 2·MAN_W+2.
  - Exponent E = expA+expB−BIAS, computed signed in EXP_W+2 bits.
  - If P MSB=1: E+=1 and take the fraction from P[2·MAN_W:MAN_W+1]. Otherwise take it from P[2·MAN_W−1:MAN_W].
  - Guard = next lower bit; sticky = OR of all remaining lower bits.
  - Round up iff guard & (sticky | frac LSB). If rounding carries out of the fraction: frac=0, E+=1.
  - After rounding, E ≥ 2^EXP_W−1 → signed Inf with the Inf flag (overflow).
  - After rounding, E ≤ 0 → signed zero with flag 1000 (underflow flush).
  - Otherwise flag 0000.
- The special-case decision is made in stage 1 and carried down the pipe; it overrides the normal path in stage 3.

## Timing
- Stages:
  - S1: classify operands, compute sign and E, register the mantissas.
  - S2: mantissa multiply.
  - S3: normalise, round, overflow/underflow, pack.
- Each stage has a valid bit. The output register is the S3 register.
- Latency is 3 cycles from the accept edge to out_valid, with no stall.
- Throughput is 1 result per cycle.
- Advance enable: en = ~out_valid | out_ready. in_ready = en. All stages shift together when en=1 (bubbles propagate as valid=0).
- Transfers:
  - Input transfer happens on in_valid & in_ready.
  - Output transfer happens on out_valid & out_ready.
  - With out_valid=1, dataR and casesspecial hold stable until the output transfer.
- in_ready depends combinationally on out_ready. There is no combinational path from in_valid to out_valid.
- Simultaneous accept and output transfer in the same cycle is allowed and is lossless.
- Reset:
  - Clears all valid bits; out_valid=0, dataR=0, casesspecial=0.
  - in_ready=1 during the reset cycle's following cycle onward.
  - Reset mid-operation discards in-flight operations; no result from before reset is ever emitted.

## Structure
- Shared package fp_pkg holds:
  - flag constants FLAG_ZERO=4'b1000, FLAG_PINF=4'b0100, FLAG_NINF=4'b0010, FLAG_NAN=4'b0001;
  - typedef fp_class_e {CLS_ZERO, CLS_NORM, CLS_INF, CLS_NAN};
  - BIAS as a function of EXP_W.
- One sub-module, fp_round_norm, implements the S3 combinational normalise/round/pack logic and is parameterised on EXP_W and MAN_W.
- Classification is a package function, fp_classify.

## Test plan
- 0x40FC0000 × 0x3E400000 (7.875×0.1875) → dataR 0x3FBD0000, flag 0000, out_valid exactly 3 cycles after accept.
- 0xC1900000 × 0x41180000 (−18×9.5) → 0xC32B0000.
- Special cases:
  - 0xFF800000 × 0x41180000 → 0xFF800000, flag 0010;
  - 0x7F800000 × 0x00000000 → 0x7FC00000, flag 0001;
  - 0x00000000 × 0x80000000 → 0x80000000, flag 1000.
- Rounding and range:
  - 0x3F800001 × 0x3FC00000 → 0x3FC00002 (tie, odd LSB, round up);
  - 0x7F000000 × 0x7F000000 → 0x7F800000, flag 0100 (overflow);
  - 0x00800000 × 0x00800000 → 0x00000000, flag 1000 (underflow).
- Backpressure:
  - Push 5 back-to-back operations with out_ready=0. in_ready must drop once 3 are in flight.
  - Release out_ready → all 5 results appear in order, no loss or duplication.
- Reset:
  - Assert reset with 2 operations in flight → next cycle out_valid=0.
  - No stale result is ever emitted.
  - A new operation after reset returns its result 3 cycles after accept.
- Parameter sweep: run with EXP_W=5, MAN_W=10 (half precision); 0x3C00 × 0x4000 → 0x4000.

Source files
------------

// File: rtl/fp_pkg.sv
// Shared definitions for the pipelined floating-point multiplier.
// Holds the casesspecial flag encodings, the operand class enum, the
// exponent bias helper and the operand classifier.
package fp_pkg;

  localparam logic [3:0] FLAG_NONE = 4'b0000;
  localparam logic [3:0] FLAG_ZERO = 4'b1000;
  localparam logic [3:0] FLAG_PINF = 4'b0100;
  localparam logic [3:0] FLAG_NINF = 4'b0010;
  localparam logic [3:0] FLAG_NAN  = 4'b0001;

  typedef enum logic [1:0] {CLS_ZERO, CLS_NORM, CLS_INF, CLS_NAN} fp_class_e;

  function automatic int unsigned fp_bias(input int unsigned exp_w);
    return (32'd1 << (exp_w - 1)) - 32'd1;
  endfunction

  // Subnormals (exp == 0, frac != 0) classify as zero: they are flushed.
  function automatic fp_class_e fp_classify(input logic exp_ones,
                                            input logic exp_zero,
                                            input logic frac_zero);
    if (exp_zero) return CLS_ZERO;
    if (exp_ones) return frac_zero ? CLS_INF : CLS_NAN;
    return CLS_NORM;
  endfunction

endpackage

// File: rtl/fp_round_norm.sv
// Stage-3 combinational logic: normalise the mantissa product, round to
// nearest even, detect overflow/underflow and pack the result. A special
// case decided in stage 1 (spec_i != 0) overrides the arithmetic result.
//   sign_i  result sign
//   exp_i   signed biased exponent before normalisation
//   prod_i  {1,fracA} x {1,fracB}
//   spec_i  special-case flag carried from stage 1 (0000 = normal)
//   res_o   packed {sign, exp, frac}
//   flag_o  casesspecial flags
module fp_round_norm
  import fp_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                     sign_i,
  input  logic signed [EXP_W+1:0]  exp_i,
  input  logic [2*MAN_W+1:0]       prod_i,
  input  logic [3:0]               spec_i,
  output logic [EXP_W+MAN_W:0]     res_o,
  output logic [3:0]               flag_o
);

  localparam int EW2 = EXP_W + 2;
  localparam logic signed [EW2-1:0] ONE     = EW2'(1);
  localparam logic signed [EW2-1:0] ZERO    = EW2'(0);
  localparam logic signed [EW2-1:0] EXP_MAX = EW2'((1 << EXP_W) - 1);

  logic [MAN_W-1:0]       frac_t;
  logic [MAN_W:0]         frac_r;
  logic                   guard, sticky, rnd;
  logic signed [EW2-1:0]  e_n, e_r;

  always_comb begin
    // Product in [1,2): fraction sits one bit lower than in [2,4).
    frac_t = prod_i[2*MAN_W-1:MAN_W];
    guard  = prod_i[MAN_W-1];
    sticky = |prod_i[MAN_W-2:0];
    e_n    = exp_i;
    if (prod_i[2*MAN_W+1]) begin
      frac_t = prod_i[2*MAN_W:MAN_W+1];
      guard  = prod_i[MAN_W];
      sticky = |prod_i[MAN_W-1:0];
      e_n    = exp_i + ONE;
    end
    rnd    = guard & (sticky | frac_t[0]);
    frac_r = {1'b0, frac_t} + {{MAN_W{1'b0}}, rnd};
    // Carry out leaves the low fraction bits all zero already.
    e_r    = frac_r[MAN_W] ? e_n + ONE : e_n;

    res_o  = {sign_i, e_r[EXP_W-1:0], frac_r[MAN_W-1:0]};
    flag_o = FLAG_NONE;
    if (spec_i == FLAG_NAN) begin
      res_o  = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
      flag_o = FLAG_NAN;
    end else if (spec_i == FLAG_PINF || spec_i == FLAG_NINF) begin
      res_o  = {sign_i, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      flag_o = spec_i;
    end else if (spec_i == FLAG_ZERO) begin
      res_o  = {sign_i, {(EXP_W+MAN_W){1'b0}}};
      flag_o = FLAG_ZERO;
    end else if (e_r >= EXP_MAX) begin
      res_o  = {sign_i, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      flag_o = sign_i ? FLAG_NINF : FLAG_PINF;
    end else if (e_r <= ZERO) begin
      res_o  = {sign_i, {(EXP_W+MAN_W){1'b0}}};
      flag_o = FLAG_ZERO;
    end
  end

endmodule

// File: rtl/fp_multiplier_pipe.sv
// Pipelined IEEE-754-style multiplier, 3 stages, valid/ready on both sides.
//   S1: classify, sign, exponent sum, register mantissas
//   S2: mantissa multiply
//   S3: normalise/round/pack (fp_round_norm), output register
// All stages advance together on en = ~out_valid | out_ready; in_ready = en.
//   clk, reset        clock, synchronous active-high reset
//   in_valid/in_ready operand handshake, dataA/dataB {sign, exp, frac}
//   out_valid/out_ready result handshake, dataR product
//   casesspecial      {zero, +inf, -inf, nan}
module fp_multiplier_pipe
  import fp_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [EXP_W+MAN_W:0]   dataA,
  input  logic [EXP_W+MAN_W:0]   dataB,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EXP_W+MAN_W:0]   dataR,
  output logic [3:0]             casesspecial
);

  localparam int EW2 = EXP_W + 2;
  localparam int PW  = 2*MAN_W + 2;
  localparam logic signed [EW2-1:0] BIAS_S = EW2'(fp_bias(EXP_W));

  logic en;
  logic [2:0] vld_q;  // [0]=S1, [1]=S2, [2]=S3 (output)

  assign en        = ~vld_q[2] | out_ready;
  assign in_ready  = en;
  assign out_valid = vld_q[2];

  // ---- S1 combinational
  logic               sa, sb, sign_d;
  logic [EXP_W-1:0]   ea, eb;
  logic [MAN_W-1:0]   fa, fb;
  fp_class_e          ca, cb;
  logic [3:0]         spec_d;
  logic signed [EW2-1:0] exp_d;

  assign {sa, ea, fa} = dataA;
  assign {sb, eb, fb} = dataB;
  assign ca     = fp_classify(&ea, ~|ea, ~|fa);
  assign cb     = fp_classify(&eb, ~|eb, ~|fb);
  assign sign_d = sa ^ sb;
  assign exp_d  = $signed({2'b00, ea}) + $signed({2'b00, eb}) - BIAS_S;

  always_comb begin
    spec_d = FLAG_NONE;
    if (ca == CLS_NAN || cb == CLS_NAN ||
        (ca == CLS_INF && cb == CLS_ZERO) || (ca == CLS_ZERO && cb == CLS_INF))
      spec_d = FLAG_NAN;
    else if (ca == CLS_INF || cb == CLS_INF)
      spec_d = sign_d ? FLAG_NINF : FLAG_PINF;
    else if (ca == CLS_ZERO || cb == CLS_ZERO)
      spec_d = FLAG_ZERO;
  end

  // ---- pipeline state
  logic                  sign1_q, sign2_q;
  logic [3:0]            spec1_q, spec2_q;
  logic signed [EW2-1:0] exp1_q, exp2_q;
  logic [MAN_W:0]        mana1_q, manb1_q;
  logic [PW-1:0]         prod2_q, prod_d;
  logic [EXP_W+MAN_W:0]  res_q, res_d;
  logic [3:0]            flag_q, flag_d;

  assign prod_d = PW'(mana1_q) * PW'(manb1_q);

  fp_round_norm #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_round (
    .sign_i (sign2_q),
    .exp_i  (exp2_q),
    .prod_i (prod2_q),
    .spec_i (spec2_q),
    .res_o  (res_d),
    .flag_o (flag_d)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_q  <= '0;
      res_q  <= '0;
      flag_q <= '0;
    end else if (en) begin
      vld_q <= {vld_q[1:0], in_valid};
      // Output only reloads on a real result so bubbles leave it quiet.
      if (vld_q[1]) begin
        res_q  <= res_d;
        flag_q <= flag_d;
      end
    end
  end

  // Datapath registers need no reset: validity is tracked by vld_q alone.
  always_ff @(posedge clk) begin
    if (en) begin
      sign1_q <= sign_d;
      spec1_q <= spec_d;
      exp1_q  <= exp_d;
      mana1_q <= {1'b1, fa};
      manb1_q <= {1'b1, fb};
      sign2_q <= sign1_q;
      spec2_q <= spec1_q;
      exp2_q  <= exp1_q;
      prod2_q <= prod_d;
    end
  end

  assign dataR        = res_q;
  assign casesspecial = flag_q;

endmodule

// File: tb/tb_fp_multiplier_pipe.sv
module tb_fp_multiplier_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // single-precision DUT
  logic        reset, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] dataA, dataB, dataR;
  logic [3:0]  flags;

  fp_multiplier_pipe #(.EXP_W(8), .MAN_W(23)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .dataA(dataA), .dataB(dataB), .out_valid(out_valid), .out_ready(out_ready),
    .dataR(dataR), .casesspecial(flags)
  );

  // half-precision DUT
  logic        h_in_valid, h_in_ready, h_out_valid, h_out_ready;
  logic [15:0] h_dataA, h_dataB, h_dataR;
  logic [3:0]  h_flags;

  fp_multiplier_pipe #(.EXP_W(5), .MAN_W(10)) dut_h (
    .clk(clk), .reset(reset), .in_valid(h_in_valid), .in_ready(h_in_ready),
    .dataA(h_dataA), .dataB(h_dataB), .out_valid(h_out_valid), .out_ready(h_out_ready),
    .dataR(h_dataR), .casesspecial(h_flags)
  );

  typedef struct {
    logic [31:0] r;
    logic [3:0]  f;
    int          cyc;
    bit          lat;
    string       nm;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;
  int   n_out = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: every output transfer pops one expectation in order.
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      n_out++;
      n_checks++;
      if (sb.size() == 0) begin
        $display("FAIL unexpected_output: got %h/%b required no output", dataR, flags);
      end else begin
        mon_e = sb.pop_front();
        if (dataR !== mon_e.r || flags !== mon_e.f)
          $display("FAIL %s: got %h/%b required %h/%b", mon_e.nm, dataR, flags, mon_e.r, mon_e.f);
        else
          n_pass++;
        if (mon_e.lat) begin
          n_checks++;
          if (cyc - mon_e.cyc !== 3)
            $display("FAIL %s_latency: got %0d required 3", mon_e.nm, cyc - mon_e.cyc);
          else
            n_pass++;
        end
      end
    end
  end

  // Called just after a rising edge; returns just after the accept edge.
  task automatic send(input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] r, input logic [3:0] f,
                      input string nm, input bit lat);
    int   w = 0;
    bit   ok = 1'b1;
    exp_t e;
    in_valid = 1'b1;
    dataA = a;
    dataB = b;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      w++;
      if (w > 50) begin
        n_checks++;
        $display("FAIL %s_accept_timeout: got in_ready=0 required 1", nm);
        ok = 1'b0;
        break;
      end
      @(posedge clk); #1;
    end
    if (ok) begin
      e.r = r; e.f = f; e.cyc = cyc; e.lat = lat; e.nm = nm;
      sb.push_back(e);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain(input string nm);
    int w = 0;
    while (sb.size() != 0 && w < 100) begin
      @(posedge clk); #1;
      w++;
    end
    if (sb.size() != 0) begin
      n_checks++;
      $display("FAIL %s_drain_timeout: got %0d pending required 0", nm, sb.size());
      sb.delete();
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    h_in_valid = 1'b0; h_out_ready = 1'b1;
    dataA = '0; dataB = '0; h_dataA = '0; h_dataB = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b required 0", out_valid); else n_pass++;
    n_checks++; if (dataR !== 32'h0) $display("FAIL reset_dataR: got %h required 0", dataR); else n_pass++;
    n_checks++; if (flags !== 4'b0) $display("FAIL reset_flags: got %b required 0000", flags); else n_pass++;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    n_checks++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b required 1", in_ready); else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    send(32'h40FC0000, 32'h3E400000, 32'h3FBD0000, 4'b0000, "mul_7875_01875", 1'b1);
    drain("basic1");
    send(32'hC1900000, 32'h41180000, 32'hC32B0000, 4'b0000, "mul_m18_95", 1'b1);
    drain("basic2");
  endtask

  task automatic test_special();
    send(32'hFF800000, 32'h41180000, 32'hFF800000, 4'b0010, "ninf_x_norm", 1'b0);
    send(32'h7F800000, 32'h00000000, 32'h7FC00000, 4'b0001, "inf_x_zero", 1'b0);
    send(32'h00000000, 32'h80000000, 32'h80000000, 4'b1000, "zero_x_negzero", 1'b0);
    send(32'h7FC12345, 32'h3F800000, 32'h7FC00000, 4'b0001, "nan_in", 1'b0);
    send(32'h7F800000, 32'hFF800000, 32'hFF800000, 4'b0010, "inf_x_ninf", 1'b0);
    send(32'h00400000, 32'h3F800000, 32'h00000000, 4'b1000, "subnormal_flush", 1'b0);
    drain("special");
  endtask

  task automatic test_round_range();
    send(32'h3F800001, 32'h3FC00000, 32'h3FC00002, 4'b0000, "tie_odd_up", 1'b0);
    send(32'h3F800003, 32'h3FC00000, 32'h3FC00004, 4'b0000, "tie_even_keep", 1'b0);
    send(32'h7F000000, 32'h7F000000, 32'h7F800000, 4'b0100, "overflow", 1'b0);
    send(32'hFF000000, 32'h7F000000, 32'hFF800000, 4'b0010, "overflow_neg", 1'b0);
    send(32'h00800000, 32'h00800000, 32'h00000000, 4'b1000, "underflow", 1'b0);
    drain("round_range");
  endtask

  task automatic test_back_to_back();
    int out0;
    out0 = n_out;
    out_ready = 1'b0;
    send(32'h40FC0000, 32'h3E400000, 32'h3FBD0000, 4'b0000, "bp0", 1'b0);
    send(32'hC1900000, 32'h41180000, 32'hC32B0000, 4'b0000, "bp1", 1'b0);
    send(32'h3F800001, 32'h3FC00000, 32'h3FC00002, 4'b0000, "bp2", 1'b0);
    fork
      begin
        send(32'h7F000000, 32'h7F000000, 32'h7F800000, 4'b0100, "bp3", 1'b0);
        send(32'h3F800000, 32'h40000000, 32'h40000000, 4'b0000, "bp4", 1'b0);
      end
      begin
        @(negedge clk);
        n_checks++; if (in_ready !== 1'b0) $display("FAIL bp_in_ready_full: got %b required 0", in_ready); else n_pass++;
        n_checks++; if (out_valid !== 1'b1) $display("FAIL bp_out_valid: got %b required 1", out_valid); else n_pass++;
        repeat (3) @(negedge clk);
        n_checks++;
        if (dataR !== 32'h3FBD0000 || flags !== 4'b0000)
          $display("FAIL bp_hold: got %h/%b required 3fbd0000/0000", dataR, flags);
        else n_pass++;
        @(posedge clk); #1;
        out_ready = 1'b1;
      end
    join
    drain("back_to_back");
    n_checks++;
    if (n_out - out0 !== 5) $display("FAIL bp_count: got %0d required 5", n_out - out0); else n_pass++;
  endtask

  task automatic test_reset_inflight();
    int seen = 0;
    out_ready = 1'b1;
    send(32'h40FC0000, 32'h3E400000, 32'h3FBD0000, 4'b0000, "stale0", 1'b0);
    send(32'hC1900000, 32'h41180000, 32'hC32B0000, 4'b0000, "stale1", 1'b0);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    sb.delete();
    @(negedge clk);
    n_checks++; if (out_valid !== 1'b0) $display("FAIL rst_flight_out_valid: got %b required 0", out_valid); else n_pass++;
    repeat (6) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    n_checks++; if (seen !== 0) $display("FAIL rst_flight_stale: got %0d outputs required 0", seen); else n_pass++;
    @(posedge clk); #1;
    send(32'hC1900000, 32'h41180000, 32'hC32B0000, 4'b0000, "after_reset", 1'b1);
    drain("after_reset");
  endtask

  task automatic test_half();
    logic [15:0] ta [2];
    logic [15:0] tb [2];
    logic [15:0] tr [2];
    ta[0] = 16'h3C00; tb[0] = 16'h4000; tr[0] = 16'h4000;
    ta[1] = 16'h3DA8; tb[1] = 16'h3DA8; tr[1] = 16'h4000;  // rounding carries into exponent
    for (int i = 0; i < 2; i++) begin
      int n = 0;
      h_in_valid = 1'b1; h_dataA = ta[i]; h_dataB = tb[i];
      @(negedge clk);
      n_checks++; if (h_in_ready !== 1'b1) $display("FAIL half%0d_in_ready: got %b required 1", i, h_in_ready); else n_pass++;
      @(posedge clk); #1;
      h_in_valid = 1'b0;
      while (n < 10) begin
        @(negedge clk);
        n++;
        if (h_out_valid) break;
      end
      n_checks++;
      if (n !== 3) $display("FAIL half%0d_latency: got %0d required 3", i, n); else n_pass++;
      n_checks++;
      if (h_dataR !== tr[i] || h_flags !== 4'b0000)
        $display("FAIL half%0d_result: got %h/%b required %h/0000", i, h_dataR, h_flags, tr[i]);
      else n_pass++;
      @(posedge clk); #1;
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_special();
    test_round_range();
    test_back_to_back();
    test_reset_inflight();
    test_half();
    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
